sum_latch_seq: RTL

- Frame sequencer between the UART byte interface and the sum/latch datapath inside the top-level tile.
- Parses a received command frame: header, operand A, operand B, and (with the optional feature) a checksum.
- Computes and latches A+B, then sends the 2-byte result back through the UART transmitter with a start/busy handshake.
- Provides inter-byte timeout recovery and a sticky error flag.

---
 rtl/sum_latch_pkg.sv | 30 +++
 rtl/sum_latch_timeout.sv | 42 ++++
 rtl/sum_latch_seq.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/sum_latch_pkg.sv
// sum_latch_pkg: shared types and constants for the sum/latch frame sequencer.
// Contents: FSM state enum, default frame header, response length,
//           result width and the frame checksum helper.
package sum_latch_pkg;

  localparam int unsigned OPW        = 8;        // operand width
  localparam int unsigned RES_W      = OPW + 1;  // {carry, sum}
  localparam int unsigned RESP_BYTES = 2;        // result bytes sent back
  localparam logic [OPW-1:0] HEADER_DEF = 8'hA5;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_GET_A   = 4'd1,
    ST_GET_B   = 4'd2,
    ST_GET_CK  = 4'd3,
    ST_CALC    = 4'd4,
    ST_SEND_LO = 4'd5,
    ST_WAIT_LO = 4'd6,
    ST_SEND_HI = 4'd7,
    ST_WAIT_HI = 4'd8
  } state_e;

  // Expected checksum byte of a frame: header ^ A ^ B.
  function automatic logic [OPW-1:0] frame_checksum(input logic [OPW-1:0] hdr,
                                                    input logic [OPW-1:0] a,
                                                    input logic [OPW-1:0] b);
    return hdr ^ a ^ b;
  endfunction

endpackage

// File: rtl/sum_latch_timeout.sv
// sum_latch_timeout: saturating cycle counter with synchronous clear.
// Ports: clk, rst_n (async active-low), clr_i (restart count at 0),
//        en_i (count enable), tc_o (high while count == TIMEOUT_CYC-1).
module sum_latch_timeout #(
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int unsigned CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] TC_VAL = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: clear wins, then count up and saturate at terminal value.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != TC_VAL)) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == TC_VAL);

endmodule

// File: rtl/sum_latch_seq.sv
// sum_latch_seq: frame sequencer between the UART byte interface and the
// sum/latch datapath. Receives HEADER, A, B [, checksum], latches A+B and
// sends {sum[7:0]} then {7'b0, carry} through a start/busy handshake.
// Ports: clk, rst_n (async active-low), ena (freeze when low),
//        rx_valid/rx_data (received byte), tx_busy (UART busy),
//        tx_start/tx_data (transmit request), sum_out (latched result),
//        busy (not IDLE), err (sticky timeout/checksum error).
// Build option: define SUM_LATCH_CHECKSUM_EN to require a 4th byte
//               equal to HEADER^A^B before the sum is computed.
module sum_latch_seq
  import sum_latch_pkg::*;
#(
  parameter int unsigned    WIDTH       = OPW,
  parameter logic [WIDTH-1:0] HEADER    = HEADER_DEF,
  parameter int unsigned    TIMEOUT_CYC = 100000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             rx_valid,
  input  logic [WIDTH-1:0] rx_data,
  input  logic             tx_busy,
  output logic             tx_start,
  output logic [WIDTH-1:0] tx_data,
  output logic [WIDTH:0]   sum_out,
  output logic             busy,
  output logic             err
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH:0]   sum_q, sum_d;
  logic [WIDTH-1:0] tx_data_q, tx_data_d;
  logic             tx_start_q, tx_start_d;
  logic             err_q, err_d;
  logic             busy_q;
  logic             seen_q, seen_d;   // tx_busy observed high in WAIT_*
  logic             tc_s;
  logic             tmo_clr_s;

  // Timer restarts on every state change and every accepted byte.
  assign tmo_clr_s = ena && (rx_valid || (state_d != state_q));

  sum_latch_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (tmo_clr_s),
    .en_i  (ena),
    .tc_o  (tc_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; rx_valid takes priority over a coincident timeout.
  always_comb begin
    state_d = state_q;
    if (!ena) begin
      state_d = state_q;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rx_valid && (rx_data == HEADER)) state_d = ST_GET_A;
          else                                 state_d = ST_IDLE;
        end
        ST_GET_A: begin
          if (rx_valid)  state_d = ST_GET_B;
          else if (tc_s) state_d = ST_IDLE;
          else           state_d = ST_GET_A;
        end
        ST_GET_B: begin
`ifdef SUM_LATCH_CHECKSUM_EN
          if (rx_valid)  state_d = ST_GET_CK;
`else
          if (rx_valid)  state_d = ST_CALC;
`endif
          else if (tc_s) state_d = ST_IDLE;
          else           state_d = ST_GET_B;
        end
`ifdef SUM_LATCH_CHECKSUM_EN
        ST_GET_CK: begin
          if (rx_valid) begin
            if (rx_data == frame_checksum(HEADER, a_q, b_q)) state_d = ST_CALC;
            else                                             state_d = ST_IDLE;
          end else if (tc_s) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_GET_CK;
          end
        end
`endif
        ST_CALC:    state_d = ST_SEND_LO;
        ST_SEND_LO: begin
          if (!tx_busy) state_d = ST_WAIT_LO;
          else          state_d = ST_SEND_LO;
        end
        ST_WAIT_LO: begin
          if (seen_q && !tx_busy)  state_d = ST_SEND_HI;
          else if (!seen_q && tc_s) state_d = ST_IDLE;
          else                     state_d = ST_WAIT_LO;
        end
        ST_SEND_HI: begin
          if (!tx_busy) state_d = ST_WAIT_HI;
          else          state_d = ST_SEND_HI;
        end
        ST_WAIT_HI: begin
          if (seen_q && !tx_busy)   state_d = ST_IDLE;
          else if (!seen_q && tc_s) state_d = ST_IDLE;
          else                      state_d = ST_WAIT_HI;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Datapath / output next values; all hold while ena is low.
  always_comb begin
    a_d        = a_q;
    b_d        = b_q;
    sum_d      = sum_q;
    err_d      = err_q;
    seen_d     = seen_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    if (!ena) begin
      tx_start_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rx_valid && (rx_data == HEADER)) err_d = 1'b0;
          else                                 err_d = err_q;
        end
        ST_GET_A: begin
          if (rx_valid)  a_d   = rx_data;
          else if (tc_s) err_d = 1'b1;
          else           a_d   = a_q;
        end
        ST_GET_B: begin
          if (rx_valid)  b_d   = rx_data;
          else if (tc_s) err_d = 1'b1;
          else           b_d   = b_q;
        end
`ifdef SUM_LATCH_CHECKSUM_EN
        ST_GET_CK: begin
          if (rx_valid) begin
            if (rx_data != frame_checksum(HEADER, a_q, b_q)) err_d = 1'b1;
            else                                             err_d = err_q;
          end else if (tc_s) begin
            err_d = 1'b1;
          end else begin
            err_d = err_q;
          end
        end
`endif
        ST_CALC: sum_d = {1'b0, a_q} + {1'b0, b_q};
        ST_SEND_LO: begin
          seen_d = 1'b0;
          if (!tx_busy) begin
            tx_start_d = 1'b1;
            tx_data_d  = sum_q[WIDTH-1:0];
          end else begin
            tx_start_d = 1'b0;
          end
        end
        ST_SEND_HI: begin
          seen_d = 1'b0;
          if (!tx_busy) begin
            tx_start_d = 1'b1;
            tx_data_d  = {{(WIDTH-1){1'b0}}, sum_q[WIDTH]};
          end else begin
            tx_start_d = 1'b0;
          end
        end
        ST_WAIT_LO, ST_WAIT_HI: begin
          seen_d = seen_q | tx_busy;
          // Transmitter never acknowledged the start pulse.
          if (!seen_q && tc_s) err_d = 1'b1;
          else                 err_d = err_q;
        end
        default: tx_start_d = 1'b0;
      endcase
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q        <= '0;
      b_q        <= '0;
      sum_q      <= '0;
      err_q      <= 1'b0;
      seen_q     <= 1'b0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      a_q        <= a_d;
      b_q        <= b_d;
      sum_q      <= sum_d;
      err_q      <= err_d;
      seen_q     <= seen_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      busy_q     <= (state_d != ST_IDLE);
    end
  end

  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign sum_out  = sum_q;
  assign busy     = busy_q;
  assign err      = err_q;

endmodule
